// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 data-memory responder: access-size
// encodings, responder FSM states and the wait-state counter width.
package rv32_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/rv32_dmem_lane.sv
// Combinational byte-lane steering for the data-memory responder.
// Produces store byte-enables and replicated store data, extracts and
// sign/zero-extends load data, and flags naturally misaligned accesses.
// When the access is misaligned the low address bits are treated as if
// forced to natural alignment (half uses addr[1], word ignores addr[1:0]).
module rv32_dmem_lane
   import rv32_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_load_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_ram_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata_lane,
   output logic [31:0] o_rdata_ext,
   output logic        o_misalign
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store lane enables/data and load extraction/extension by access size
   always_comb begin
      o_be         = 4'b0000;
      o_wdata_lane = 32'h0000_0000;
      o_rdata_ext  = 32'h0000_0000;
      o_misalign   = 1'b0;
      w_shifted    = i_ram_word >> {i_addr_lo, 3'b000};
      w_byte       = w_shifted[7:0];
      if (i_addr_lo[1]) begin
         w_half = i_ram_word[31:16];
      end else begin
         w_half = i_ram_word[15:0];
      end
      case (i_size)
         SIZE_B: begin
            o_be         = 4'b0001 << i_addr_lo;
            o_wdata_lane = {4{i_wdata[7:0]}};
            if (i_load_unsigned) begin
               o_rdata_ext = {24'h00_0000, w_byte};
            end else begin
               o_rdata_ext = {{24{w_byte[7]}}, w_byte};
            end
         end
         SIZE_H: begin
            o_misalign   = i_addr_lo[0];
            o_wdata_lane = {2{i_wdata[15:0]}};
            if (i_addr_lo[1]) begin
               o_be = 4'b1100;
            end else begin
               o_be = 4'b0011;
            end
            if (i_load_unsigned) begin
               o_rdata_ext = {16'h0000, w_half};
            end else begin
               o_rdata_ext = {{16{w_half[15]}}, w_half};
            end
         end
         SIZE_W: begin
            o_misalign   = (i_addr_lo != 2'b00);
            o_be         = 4'b1111;
            o_wdata_lane = i_wdata;
            o_rdata_ext  = i_ram_word;
         end
         default: begin
            o_be         = 4'b0000;
            o_wdata_lane = 32'h0000_0000;
            o_rdata_ext  = 32'h0000_0000;
            o_misalign   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the rv32 core's data-master port.
// Stalls the core with waitrequest for WAIT_STATES extra cycles, then
// commits a byte/half/word store into the internal RAM or latches an
// extended load word, reporting err on the one-cycle completion beat.
// Optional feature macro RV32_DMEM_ERR_EN: when defined, misaligned and
// out-of-range accesses are errors; otherwise low address bits are forced
// to alignment and upper bits wrap modulo the memory size.
module rv32_dmem_responder
   import rv32_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        waitrequest,
   output logic        err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic [31:0]        r_mem [0:DEPTH-1];

   logic                  w_req;
   logic [ADDR_WIDTH-1:0] w_word_addr;
   logic [31:0]           w_ram_word;
   logic [31:0]           w_addr_hi;
   logic                  w_oor;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata_lane;
   logic [31:0]           w_load;
   logic                  w_misalign;
   logic                  w_err;
   logic                  w_commit;
   logic                  w_do_write;
   logic                  w_wait;

   assign w_req       = read | write;
   assign w_word_addr = address[ADDR_WIDTH+1:2];
   assign w_ram_word  = r_mem[w_word_addr];
   assign w_addr_hi   = address >> (ADDR_WIDTH + 2);
   assign w_oor       = |w_addr_hi;

   rv32_dmem_lane u_lane (
      .i_size          (size),
      .i_addr_lo       (address[1:0]),
      .i_load_unsigned (load_unsigned),
      .i_wdata         (wdata),
      .i_ram_word      (w_ram_word),
      .o_be            (w_be),
      .o_wdata_lane    (w_wdata_lane),
      .o_rdata_ext     (w_load),
      .o_misalign      (w_misalign)
   );

`ifdef RV32_DMEM_ERR_EN
   assign w_err = (read & write) | (size == 2'b11) | w_misalign | w_oor;
`else
   logic w_unused_chk;
   assign w_unused_chk = w_misalign | w_oor;
   assign w_err        = (read & write) | (size == 2'b11);
`endif

   // The access commits on the last BUSY cycle with the request still held
   assign w_commit   = (r_state == ST_BUSY) & w_req & (r_cnt == {CNT_W{1'b0}}) & ~reset;
   assign w_do_write = w_commit & write & ~w_err;

   // Stall the core while a request is pending; never stall during reset
   always_comb begin
      w_wait = 1'b0;
      if (reset) begin
         w_wait = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: w_wait = w_req;
            ST_BUSY: w_wait = 1'b1;
            ST_DONE: w_wait = 1'b0;
            default: w_wait = 1'b0;
         endcase
      end
   end

   assign waitrequest = w_wait;
   assign rdata       = r_rdata;
   assign err         = r_err;

   // Responder FSM: wait-state counting, abort, commit and completion beat
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_rdata <= 32'h0000_0000;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_cnt   <= CNT_W'(WAIT_STATES);
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_req) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt != {CNT_W{1'b0}}) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  if (w_err) begin
                     r_rdata <= 32'h0000_0000;
                  end else if (read) begin
                     r_rdata <= w_load;
                  end
                  r_err   <= w_err;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Byte-lane RAM write for a committed, error-free store
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_word_addr][8*b +: 8] <= w_wdata_lane[8*b +: 8];
            end
         end
      end
   end

endmodule
